pll_dyn_cfg_ctrl: RTL and testbench
===================================

# pll_dyn_cfg_ctrl

Dynamic-reconfiguration and lock-sequencing controller for the GTP_PLL_E3 wrapper generation that exposes dynamic dividers. It holds per-output divider/duty settings, applies new settings through a reset/relock sequence with timeout and retry, and qualifies lock. It also generates a single downstream active-low clock-domain reset. It sits between the system control logic (register bank / Ethernet command path) and the PLL dynamic ports: RATIOI, RATIOF, RATIO0..4, DUTY0..4, RST and LOCK.

## Interface
- NUM_OUT, 5, number of PLL outputs driven (1..5)
- RATIO_W, 10, divider/duty field width
- DEF_RATIOI, 2, reset-value input divider
- DEF_RATIOF, 24, reset-value feedback divider
- DEF_RATIOO, 60, reset-value output divider (all outputs)
- DEF_DUTYO, 60, reset-value duty (half-VCO-period units; DEF_DUTYO = DEF_RATIOO gives 50 %)
- RST_CYCLES, 16, PLL reset pulse length in cycles (>=2)
- LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK per attempt
- LOCK_STABLE, 1024, consecutive synced-lock cycles required
- MAX_RETRY, 3, relock retries after first attempt
- sys_clk  in  1  controller clock (free-running, independent of PLL)
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_ratioi  in  RATIO_W  requested input divider
- cfg_ratiof  in  RATIO_W  requested feedback divider
- cfg_ratioo  in  NUM_OUT*RATIO_W  requested output dividers, output k at [k*RATIO_W +: RATIO_W]
- cfg_duty  in  NUM_OUT*RATIO_W  requested duties, same packing
- pll_lock  in  1  raw PLL LOCK (asynchronous)
- dyn_idiv, dyn_fdiv  out  RATIO_W each  to PLL RATIOI/RATIOF
- dyn_odiv, dyn_duty  out  NUM_OUT*RATIO_W  to PLL RATIOk/DUTYk
- pll_rst  out  1  PLL RST, active high
- locked  out  1  qualified lock
- clk_rst_n  out  1  downstream domain reset, active low
- cfg_done  out  1  one-cycle pulse, relock completed
- cfg_err  out  1  one-cycle pulse, error
- err_code  out  2  01 bad config, 10 lock failure, 11 lock lost; held until next cfg_err

## Operation
- pll_lock passes through a 2-flop synchroniser (lock_s) before any use.
- States: RST_HOLD, WAIT_LOCK, STABLE, LOCKED, FAILED.
- Reset (rst_n=0): state RST_HOLD, counters 0, retry 0. Outputs: dyn_* = defaults, pll_rst=1, cfg_ready=0, locked=0, clk_rst_n=0, cfg_done=0, cfg_err=0, err_code=00.
- RST_HOLD: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the timeout counter at 0.
- WAIT_LOCK: lock_s=1 -> STABLE. Timeout counter reaches LOCK_TIMEOUT:
  - retry<MAX_RETRY -> retry+1, RST_HOLD.
  - otherwise -> FAILED, cfg_err pulse, err_code=10.
- STABLE: count consecutive lock_s=1 cycles. lock_s=0 -> WAIT_LOCK, timeout counter not cleared. Count reaches LOCK_STABLE -> LOCKED, cfg_done pulse, retry=0.
- LOCKED: locked=1, clk_rst_n=1, cfg_ready=1. lock_s=0 -> RST_HOLD; locked and clk_rst_n drop on the same edge; cfg_err pulse, err_code=11.
- FAILED: pll_rst=1, cfg_ready=1, locked=0, clk_rst_n=0. Leaves only on an accepted configuration.
- Accept = cfg_valid & cfg_ready. A configuration is valid when ratioi, ratiof and every ratioo are nonzero, and every duty satisfies 1 <= duty <= 2*ratio-1 (compare at RATIO_W+1 bits).
  - Invalid -> cfg_err pulse, err_code=01. State, dyn_* and locked unchanged.
  - Valid -> dyn_* load, retry=0, RST_HOLD; locked=0, clk_rst_n=0, cfg_ready=0.
- cfg_ready is 0 in RST_HOLD, WAIT_LOCK and STABLE; cfg_valid is ignored there.

## Timing
- All outputs are registered.
- Accept at edge N -> dyn_* new, pll_rst=1, locked=0, cfg_ready=0 visible after edge N+1.
- pll_rst high for exactly RST_CYCLES cycles per attempt.
- Bad-config cfg_err visible after edge N+1.
- pll_lock rise (held) in WAIT_LOCK -> locked and cfg_done after 2 + LOCK_STABLE + 1 cycles.
- Lock loss in LOCKED -> locked=0, clk_rst_n=0, pll_rst=1 three edges after the pll_lock fall (2 sync + 1).
- dyn_* stable whenever pll_rst=0.
- Simultaneous accept and lock loss in LOCKED: lock loss wins. Configuration dropped, err_code=11.
- rst_n low in any state returns to reset values on the next edge.

## Test plan
- Power-up with defaults, pll_lock raised 100 cycles after reset release, RST_CYCLES=16, LOCK_STABLE=1024 -> pll_rst high 16 cycles; locked and cfg_done 1027 cycles after pll_lock rise; dyn_idiv=2, dyn_fdiv=24, each dyn_odiv=60.
- In LOCKED, accept ratiof=30, ratioo[0]=40, duty[0]=40 -> next cycle dyn_fdiv=30, dyn_odiv[0]=40, pll_rst=1, locked=0, clk_rst_n=0; relock produces cfg_done.
- Accept ratioo[1]=0, then separately duty[2]=2*ratio -> each gives one cfg_err, err_code=01; dyn_* and locked unchanged.
- pll_lock never rises, LOCK_TIMEOUT=100, MAX_RETRY=3 -> 4 pll_rst pulses, then FAILED, cfg_err, err_code=10, cfg_ready=1.
- pll_lock glitches low 1 cycle mid-STABLE -> stable count restarts; lock glitch in LOCKED -> err_code=11, relock sequence, clk_rst_n low throughout.
- rst_n asserted mid-WAIT_LOCK after a reconfiguration -> dyn_* back to defaults, pll_rst=1, RST_HOLD.

Source files
------------

// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL dynamic-reconfiguration and lock sequencer. It holds the divider/duty settings,
// drives reset/relock with timeout and retry, qualifies lock and gates the downstream reset.
module pll_dyn_cfg_ctrl #(
  parameter int NUM_OUT      = 5,
  parameter int RATIO_W      = 10,
  parameter int DEF_RATIOI   = 2,
  parameter int DEF_RATIOF   = 24,
  parameter int DEF_RATIOO   = 60,
  parameter int DEF_DUTYO    = 60,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [RATIO_W-1:0]         cfg_ratioi,
  input  logic [RATIO_W-1:0]         cfg_ratiof,
  input  logic [NUM_OUT*RATIO_W-1:0] cfg_ratioo,
  input  logic [NUM_OUT*RATIO_W-1:0] cfg_duty,
  input  logic                       pll_lock,
  output logic [RATIO_W-1:0]         dyn_idiv,
  output logic [RATIO_W-1:0]         dyn_fdiv,
  output logic [NUM_OUT*RATIO_W-1:0] dyn_odiv,
  output logic [NUM_OUT*RATIO_W-1:0] dyn_duty,
  output logic                       pll_rst,
  output logic                       locked,
  output logic                       clk_rst_n,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic [1:0]                 err_code,
  output logic [2:0]                 dbg_state
);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(LOCK_STABLE + 1);
  localparam int RT_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_RST_HOLD  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_LOCKED    = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [RST_W-1:0] rst_cnt, rst_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [ST_W-1:0]  st_cnt, st_cnt_n;
  logic [RT_W-1:0]  retry, retry_n;
  logic             lock_meta, lock_s;
  logic             cfg_ok, accept, load, done_n, err_n;
  logic [1:0]       code_n;

  assign dbg_state = state;
  assign accept    = cfg_valid & cfg_ready;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Duty is in half-VCO periods, so the legal range is 1 .. 2*ratio-1.
  always_comb begin
    cfg_ok = (cfg_ratioi != '0) && (cfg_ratiof != '0);
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cfg_ratioo[k*RATIO_W +: RATIO_W] == '0) cfg_ok = 1'b0;
      if (cfg_duty[k*RATIO_W +: RATIO_W] == '0) cfg_ok = 1'b0;
      if ({1'b0, cfg_duty[k*RATIO_W +: RATIO_W]} >= {cfg_ratioo[k*RATIO_W +: RATIO_W], 1'b0})
        cfg_ok = 1'b0;
    end
  end

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    to_cnt_n  = to_cnt;
    st_cnt_n  = st_cnt;
    retry_n   = retry;
    load      = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    code_n    = err_code;
    case (state)
      S_RST_HOLD: begin
        if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
          state_n  = S_WAIT_LOCK;
          to_cnt_n = '0;
        end else begin
          rst_cnt_n = rst_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n  = S_STABLE;
          st_cnt_n = '0;
        end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          if (retry < RT_W'(MAX_RETRY)) begin
            retry_n   = retry + 1'b1;
            state_n   = S_RST_HOLD;
            rst_cnt_n = '0;
          end else begin
            state_n = S_FAILED;
            err_n   = 1'b1;
            code_n  = 2'b10;
          end
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        // A dropout goes back to waiting without clearing the attempt's timeout budget.
        if (!lock_s) begin
          state_n = S_WAIT_LOCK;
        end else if (st_cnt == ST_W'(LOCK_STABLE - 1)) begin
          state_n = S_LOCKED;
          done_n  = 1'b1;
          retry_n = '0;
        end else begin
          st_cnt_n = st_cnt + 1'b1;
        end
      end
      S_LOCKED, S_FAILED: begin
        // Lock loss outranks a configuration offered on the same cycle.
        if (state == S_LOCKED && !lock_s) begin
          state_n   = S_RST_HOLD;
          rst_cnt_n = '0;
          err_n     = 1'b1;
          code_n    = 2'b11;
        end else if (accept) begin
          if (cfg_ok) begin
            load      = 1'b1;
            retry_n   = '0;
            state_n   = S_RST_HOLD;
            rst_cnt_n = '0;
          end else begin
            err_n  = 1'b1;
            code_n = 2'b01;
          end
        end
      end
      default: state_n = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state     <= S_RST_HOLD;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      st_cnt    <= '0;
      retry     <= '0;
      dyn_idiv  <= RATIO_W'(DEF_RATIOI);
      dyn_fdiv  <= RATIO_W'(DEF_RATIOF);
      dyn_odiv  <= {NUM_OUT{RATIO_W'(DEF_RATIOO)}};
      dyn_duty  <= {NUM_OUT{RATIO_W'(DEF_DUTYO)}};
      pll_rst   <= 1'b1;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
      clk_rst_n <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state   <= state_n;
      rst_cnt <= rst_cnt_n;
      to_cnt  <= to_cnt_n;
      st_cnt  <= st_cnt_n;
      retry   <= retry_n;
      if (load) begin
        dyn_idiv <= cfg_ratioi;
        dyn_fdiv <= cfg_ratiof;
        dyn_odiv <= cfg_ratioo;
        dyn_duty <= cfg_duty;
      end
      pll_rst   <= (state_n == S_RST_HOLD) || (state_n == S_FAILED);
      cfg_ready <= (state_n == S_LOCKED) || (state_n == S_FAILED);
      locked    <= (state_n == S_LOCKED);
      clk_rst_n <= (state_n == S_LOCKED);
      cfg_done  <= done_n;
      cfg_err   <= err_n;
      err_code  <= code_n;
    end
  end
endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: directed sequences with literal expectations and a
// countdown-based behavioural model compared against every output on every cycle.
`timescale 1ns/1ps
module tb_pll_dyn_cfg_ctrl;
  localparam int NO = 5;
  localparam int RW = 10;
  localparam int T_RST = 16;
  localparam int T_TO = 100;
  localparam int T_ST = 1024;
  localparam int T_RETRY = 3;

  logic          sys_clk, rst_n, cfg_valid, pll_lock;
  logic [RW-1:0] cfg_ratioi, cfg_ratiof;
  logic [NO*RW-1:0] cfg_ratioo, cfg_duty;
  logic          cfg_ready, pll_rst, locked, clk_rst_n, cfg_done, cfg_err;
  logic [RW-1:0] dyn_idiv, dyn_fdiv;
  logic [NO*RW-1:0] dyn_odiv, dyn_duty;
  logic [1:0]    err_code;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  pll_dyn_cfg_ctrl #(
    .NUM_OUT(NO), .RATIO_W(RW), .DEF_RATIOI(2), .DEF_RATIOF(24), .DEF_RATIOO(60),
    .DEF_DUTYO(60), .RST_CYCLES(T_RST), .LOCK_TIMEOUT(T_TO), .LOCK_STABLE(T_ST),
    .MAX_RETRY(T_RETRY)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ratioi(cfg_ratioi), .cfg_ratiof(cfg_ratiof), .cfg_ratioo(cfg_ratioo),
    .cfg_duty(cfg_duty), .pll_lock(pll_lock), .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv),
    .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty), .pll_rst(pll_rst), .locked(locked),
    .clk_rst_n(clk_rst_n), .cfg_done(cfg_done), .cfg_err(cfg_err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- behavioural model ----------------
  localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_LOCKED = 3, P_FAILED = 4;
  int m_phase, m_hold_left, m_wait_left, m_stable_left, m_retries_left;
  logic m_s1, m_lock_s;
  logic [RW-1:0] m_idiv, m_fdiv;
  logic [NO*RW-1:0] m_odiv, m_duty;
  logic m_pll_rst, m_ready, m_locked, m_clk_rst_n, m_done, m_err;
  logic [1:0] m_code;
  bit model_live = 0;

  function automatic bit spec_valid(input logic [RW-1:0] ri, input logic [RW-1:0] rf,
                                    input logic [NO*RW-1:0] ro, input logic [NO*RW-1:0] du);
    if (ri == 0 || rf == 0) return 1'b0;
    for (int k = 0; k < NO; k++) begin
      int r, d;
      r = int'(ro[k*RW +: RW]);
      d = int'(du[k*RW +: RW]);
      if (r == 0 || d < 1 || d > 2 * r - 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_offer();
    if (spec_valid(cfg_ratioi, cfg_ratiof, cfg_ratioo, cfg_duty)) begin
      m_idiv = cfg_ratioi; m_fdiv = cfg_ratiof; m_odiv = cfg_ratioo; m_duty = cfg_duty;
      m_retries_left = T_RETRY;
      m_phase = P_HOLD; m_hold_left = T_RST;
    end else begin
      m_err = 1'b1; m_code = 2'b01;
    end
  endtask

  always @(posedge sys_clk) begin
    if (!rst_n) begin
      m_phase = P_HOLD; m_hold_left = T_RST; m_wait_left = T_TO; m_stable_left = T_ST;
      m_retries_left = T_RETRY;
      m_idiv = 10'd2; m_fdiv = 10'd24; m_odiv = {NO{10'd60}}; m_duty = {NO{10'd60}};
      m_done = 1'b0; m_err = 1'b0; m_code = 2'b00;
      m_s1 = 1'b0; m_lock_s = 1'b0;
    end else begin
      m_done = 1'b0; m_err = 1'b0;
      case (m_phase)
        P_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) begin m_phase = P_WAIT; m_wait_left = T_TO; end
        end
        P_WAIT: begin
          if (m_lock_s) begin
            m_phase = P_STABLE; m_stable_left = T_ST;
          end else begin
            m_wait_left--;
            if (m_wait_left == 0) begin
              if (m_retries_left > 0) begin
                m_retries_left--; m_phase = P_HOLD; m_hold_left = T_RST;
              end else begin
                m_phase = P_FAILED; m_err = 1'b1; m_code = 2'b10;
              end
            end
          end
        end
        P_STABLE: begin
          if (!m_lock_s) m_phase = P_WAIT;
          else begin
            m_stable_left--;
            if (m_stable_left == 0) begin
              m_phase = P_LOCKED; m_done = 1'b1; m_retries_left = T_RETRY;
            end
          end
        end
        P_LOCKED: begin
          if (!m_lock_s) begin
            m_phase = P_HOLD; m_hold_left = T_RST; m_err = 1'b1; m_code = 2'b11;
          end else if (cfg_valid && m_ready) model_offer();
        end
        default: if (cfg_valid && m_ready) model_offer();
      endcase
      m_lock_s = m_s1;
      m_s1 = pll_lock;
    end
    m_pll_rst   = (m_phase == P_HOLD) || (m_phase == P_FAILED);
    m_ready     = (m_phase == P_LOCKED) || (m_phase == P_FAILED);
    m_locked    = (m_phase == P_LOCKED);
    m_clk_rst_n = (m_phase == P_LOCKED);
    model_live  = 1;
  end

  // ---------------- scoreboard: every-cycle model compare ----------------
  always @(negedge sys_clk) begin
    if (model_live) begin
      checks++;
      if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, pll_rst, cfg_ready, locked, clk_rst_n,
           cfg_done, cfg_err, err_code} !==
          {m_idiv, m_fdiv, m_odiv, m_duty, m_pll_rst, m_ready, m_locked, m_clk_rst_n,
           m_done, m_err, m_code}) begin
        failures++;
        $display("FAIL model_cmp t=%0t st=%0d dut: idiv=%0d fdiv=%0d rst=%b rdy=%b lk=%b crn=%b done=%b err=%b code=%b model: idiv=%0d fdiv=%0d rst=%b rdy=%b lk=%b crn=%b done=%b err=%b code=%b odiv %h/%h duty %h/%h",
                 $time, dbg_state, dyn_idiv, dyn_fdiv, pll_rst, cfg_ready, locked, clk_rst_n,
                 cfg_done, cfg_err, err_code, m_idiv, m_fdiv, m_pll_rst, m_ready, m_locked,
                 m_clk_rst_n, m_done, m_err, m_code, dyn_odiv, m_odiv, dyn_duty, m_duty);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [2*RW+2*NO*RW-1:0] act,
                      input logic [2*RW+2*NO*RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    cfg_ratioi = 10'd2; cfg_ratiof = 10'd24;
    cfg_ratioo = {NO{10'd60}}; cfg_duty = {NO{10'd60}};
  endtask

  task automatic offer();
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_rst_low(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 200) begin tick(1); n++; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (cfg_done !== 1'b1 && n < 1500) begin tick(1); n++; end
  endtask

  // ---------------- directed sequences ----------------
  localparam logic [2*RW+2*NO*RW-1:0] DEF_VEC = {10'd2, 10'd24, {NO{10'd60}}, {NO{10'd60}}};

  initial begin
    int n, bad, falls, highs;
    logic prev;
    rst_n = 1'b0; cfg_valid = 1'b0; pll_lock = 1'b0;
    set_defaults();
    tick(3);
    chk1("rst_pll_rst", pll_rst, 1'b1);
    chk1("rst_cfg_ready", cfg_ready, 1'b0);
    chk1("rst_locked", locked, 1'b0);
    chk1("rst_clk_rst_n", clk_rst_n, 1'b0);
    chkn("rst_err_code", int'(err_code), 0);
    chkv("rst_dyn", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty}, DEF_VEC);

    // Power-up: reset pulse, then lock raised 100 cycles after release.
    rst_n = 1'b1;
    tick(15);
    chk1("pwr_rst_last_high", pll_rst, 1'b1);
    tick(1);
    chk1("pwr_rst_released", pll_rst, 1'b0);
    tick(84);
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 2000) begin tick(1); n++; end
    chkn("pwr_lock_latency", n, 1027);
    chk1("pwr_cfg_done", cfg_done, 1'b1);
    chk1("pwr_clk_rst_n", clk_rst_n, 1'b1);
    chk1("pwr_cfg_ready", cfg_ready, 1'b1);
    chkv("pwr_dyn", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty}, DEF_VEC);
    tick(1);
    chk1("pwr_done_one_cycle", cfg_done, 1'b0);

    // Reconfigure in LOCKED; the PLL drops lock while held in reset.
    cfg_ratiof = 10'd30; cfg_ratioo[0 +: RW] = 10'd40; cfg_duty[0 +: RW] = 10'd40;
    offer();
    pll_lock = 1'b0;
    chkn("rcfg_fdiv", int'(dyn_fdiv), 30);
    chkn("rcfg_odiv0", int'(dyn_odiv[0 +: RW]), 40);
    chkn("rcfg_duty0", int'(dyn_duty[0 +: RW]), 40);
    chk1("rcfg_pll_rst", pll_rst, 1'b1);
    chk1("rcfg_locked", locked, 1'b0);
    chk1("rcfg_clk_rst_n", clk_rst_n, 1'b0);
    chk1("rcfg_cfg_ready", cfg_ready, 1'b0);
    wait_rst_low(n);
    chkn("rcfg_rst_pulse_len", n, 16);
    pll_lock = 1'b1;
    wait_done(n);
    chkn("rcfg_done_latency", n, 1027);

    // Bad configurations in LOCKED: zero output divider, then duty = 2*ratio.
    cfg_ratioo[1*RW +: RW] = 10'd0;
    offer();
    chk1("bad0_cfg_err", cfg_err, 1'b1);
    chkn("bad0_err_code", int'(err_code), 1);
    chk1("bad0_locked", locked, 1'b1);
    chkn("bad0_fdiv_kept", int'(dyn_fdiv), 30);
    cfg_ratioo[1*RW +: RW] = 10'd60;
    tick(1);
    chk1("bad0_err_pulse", cfg_err, 1'b0);
    cfg_duty[2*RW +: RW] = 10'd120;
    offer();
    chk1("bad1_cfg_err", cfg_err, 1'b1);
    chkn("bad1_err_code", int'(err_code), 1);
    chk1("bad1_locked", locked, 1'b1);
    chkn("bad1_duty2_kept", int'(dyn_duty[2*RW +: RW]), 60);
    cfg_duty[2*RW +: RW] = 10'd60;
    tick(2);
    chkn("bad1_code_held", int'(err_code), 1);

    // One-cycle lock dropout in LOCKED colliding with a valid offer: lock loss wins.
    cfg_ratioi = 10'd3;
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk1("loss_pre_locked", locked, 1'b1);
    offer();
    chk1("loss_locked", locked, 1'b0);
    chk1("loss_clk_rst_n", clk_rst_n, 1'b0);
    chk1("loss_pll_rst", pll_rst, 1'b1);
    chk1("loss_cfg_err", cfg_err, 1'b1);
    chkn("loss_err_code", int'(err_code), 3);
    chkn("loss_cfg_dropped", int'(dyn_idiv), 2);
    n = 0; bad = 0;
    while (cfg_done !== 1'b1 && n < 1500) begin
      if (clk_rst_n !== 1'b0) bad++;
      tick(1); n++;
    end
    chkn("loss_relock_latency", n, 1041);
    chkn("loss_clk_rst_n_low", bad, 0);
    chk1("loss_relocked", locked, 1'b1);

    // Dropout in the middle of STABLE restarts the stable count; boundary duty 2*60-1.
    set_defaults();
    cfg_duty[4*RW +: RW] = 10'd119;
    offer();
    pll_lock = 1'b0;
    chkn("glitch_duty4", int'(dyn_duty[4*RW +: RW]), 119);
    chk1("glitch_no_err", cfg_err, 1'b0);
    wait_rst_low(n);
    pll_lock = 1'b1;
    tick(500);
    chk1("glitch_not_yet_locked", locked, 1'b0);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_done(n);
    chkn("glitch_restart_latency", n, 1027);

    // rst_n mid-WAIT_LOCK after a reconfiguration.
    cfg_ratiof = 10'd30;
    offer();
    pll_lock = 1'b0;
    tick(30);
    chk1("rstw_in_wait", pll_rst, 1'b0);
    chkn("rstw_fdiv_new", int'(dyn_fdiv), 30);
    rst_n = 1'b0;
    tick(1);
    chkv("rstw_dyn_default", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty}, DEF_VEC);
    chk1("rstw_pll_rst", pll_rst, 1'b1);
    chk1("rstw_cfg_ready", cfg_ready, 1'b0);
    tick(2);
    set_defaults();

    // Lock never arrives: four reset pulses then FAILED.
    rst_n = 1'b1;
    n = 0; falls = 0; highs = 0; prev = pll_rst;
    while (cfg_err !== 1'b1 && n < 1000) begin
      tick(1); n++;
      if (cfg_err !== 1'b1) begin
        if (pll_rst === 1'b1) highs++;
        if (prev === 1'b1 && pll_rst === 1'b0) falls++;
      end
      prev = pll_rst;
    end
    chkn("to_fail_cycle", n, 464);
    chkn("to_pulse_count", falls, 4);
    chkn("to_rst_high_cycles", highs, 63);
    chkn("to_err_code", int'(err_code), 2);
    chk1("to_cfg_ready", cfg_ready, 1'b1);
    chk1("to_pll_rst", pll_rst, 1'b1);
    chk1("to_locked", locked, 1'b0);

    // Out of FAILED: a bad offer keeps it there, a good one restarts the sequence.
    cfg_ratioi = 10'd0;
    offer();
    chk1("fail_bad_err", cfg_err, 1'b1);
    chkn("fail_bad_code", int'(err_code), 1);
    chk1("fail_bad_stays_rst", pll_rst, 1'b1);
    chk1("fail_bad_stays_ready", cfg_ready, 1'b1);
    set_defaults();
    tick(2);
    offer();
    chk1("fail_ok_pll_rst", pll_rst, 1'b1);
    chk1("fail_ok_ready", cfg_ready, 1'b0);
    wait_rst_low(n);
    chkn("fail_ok_rst_pulse_len", n, 16);
    pll_lock = 1'b1;
    wait_done(n);
    chkn("fail_ok_done_latency", n, 1027);
    chk1("fail_ok_locked", locked, 1'b1);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
